// File: rtl/ahb_ram_pkg.sv
// Shared AHB encodings, FSM state type and transfer-decode helpers for the
// wait-stated AHB RAM slave.
package ahb_ram_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_t;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RWAIT,
    ST_ERR1,
    ST_ERR2
  } state_t;

  // Sizes above a word and misaligned halfwords/words are rejected.
  function automatic logic xfer_legal(input logic [2:0] size, input logic [1:0] a);
    logic ok;
    case (size)
      HSIZE_BYTE: ok = 1'b1;
      HSIZE_HALF: ok = ~a[0];
      HSIZE_WORD: ok = (a == 2'b00);
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Byte-lane enables for a little-endian 32-bit bus.
  function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] a);
    logic [3:0] be;
    case (size)
      HSIZE_BYTE: be = 4'b0001 << a;
      HSIZE_HALF: be = a[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: be = 4'b1111;
      default:    be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/ahb_ram_bytemem.sv
// Simple dual-port word RAM with four byte-write lanes and a registered read
// port; a read of the word being written returns the old contents.
module ahb_ram_bytemem #(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic [3:0]            we,
  input  logic [ADDR_WIDTH-3:0] waddr,
  input  logic [31:0]           wdata,
  input  logic [ADDR_WIDTH-3:0] raddr,
  output logic [31:0]           rdata
);

  localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);

  logic [31:0] mem [DEPTH];

  // Lane writes and the synchronous read share one edge, so reads see pre-write data.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/ahb_ram_ws.sv
// AHB-Lite RAM slave with zero-wait writes, WAIT_STATES read wait states,
// a two-cycle ERROR response for illegal transfers, and write-to-read
// forwarding for back-to-back accesses to the same word.
module ahb_ram_ws
  import ahb_ram_pkg::*;
#(
  parameter int ADDR_WIDTH  = 14,
  parameter int WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic        HREADY,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);

  localparam int          IW      = ADDR_WIDTH - 2;
  localparam logic [2:0]  WS_LAST = 3'(WAIT_STATES);

  state_t                state;
  logic [1:0]            wcnt;
  logic                  hreadyout_r;
  logic                  hresp_r;
  logic                  wr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [2:0]            size_q;
  logic [3:0]            fwd_mask;
  logic [31:0]           fwd_data;
  logic [31:0]           ram_q;

  logic                  slot_open;
  logic                  acc;
  logic                  legal;
  logic                  wr_done;
  logic                  same_word;
  logic [3:0]            we;
  logic [IW-1:0]         raddr;
  logic [2:0]            wcnt_inc;
  logic                  unused_bits;

  // A new address phase can only land while the previous data phase is completing.
  assign slot_open = (state == ST_IDLE) || (state == ST_ERR2);
  assign acc       = HSEL & HTRANS[1] & HREADY & slot_open;
  assign legal     = xfer_legal(HSIZE, HADDR[1:0]);
  assign wr_done   = wr_q & HREADY;
  assign same_word = (addr_q[ADDR_WIDTH-1:2] == HADDR[ADDR_WIDTH-1:2]);
  assign we        = wr_done ? byte_en(size_q, addr_q[1:0]) : 4'b0000;
  assign raddr     = (state == ST_RWAIT) ? addr_q[ADDR_WIDTH-1:2] : HADDR[ADDR_WIDTH-1:2];
  assign wcnt_inc  = {1'b0, wcnt} + 3'd1;
  assign unused_bits = ^{HTRANS[0], HADDR[31:ADDR_WIDTH]};

  ahb_ram_bytemem #(.ADDR_WIDTH(ADDR_WIDTH)) u_mem (
    .clk   (HCLK),
    .we    (we),
    .waddr (addr_q[ADDR_WIDTH-1:2]),
    .wdata (HWDATA),
    .raddr (raddr),
    .rdata (ram_q)
  );

  // Response FSM; HREADYOUT/HRESP are registered alongside the next state.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state       <= ST_IDLE;
      hreadyout_r <= 1'b1;
      hresp_r     <= HRESP_OKAY;
      wcnt        <= 2'd0;
    end else begin
      case (state)
        ST_IDLE, ST_ERR2: begin
          if (acc && !legal) begin
            state       <= ST_ERR1;
            hreadyout_r <= 1'b0;
            hresp_r     <= HRESP_ERROR;
          end else if (acc && !HWRITE && (WAIT_STATES > 0)) begin
            state       <= ST_RWAIT;
            hreadyout_r <= 1'b0;
            hresp_r     <= HRESP_OKAY;
            wcnt        <= 2'd0;
          end else begin
            state       <= ST_IDLE;
            hreadyout_r <= 1'b1;
            hresp_r     <= HRESP_OKAY;
          end
        end
        ST_RWAIT: begin
          wcnt <= wcnt_inc[1:0];
          if (wcnt_inc == WS_LAST) begin
            state       <= ST_IDLE;
            hreadyout_r <= 1'b1;
            hresp_r     <= HRESP_OKAY;
          end
        end
        ST_ERR1: begin
          state       <= ST_ERR2;
          hreadyout_r <= 1'b1;
          hresp_r     <= HRESP_ERROR;
        end
        default: begin
          state       <= ST_IDLE;
          hreadyout_r <= 1'b1;
          hresp_r     <= HRESP_OKAY;
        end
      endcase
    end
  end

  // Data-phase control: pending write flag and forwarding lane mask.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      wr_q     <= 1'b0;
      fwd_mask <= 4'b0000;
    end else begin
      if (acc)         wr_q <= legal & HWRITE;
      else if (HREADY) wr_q <= 1'b0;
      // Only the read issued in the same edge as the write sees stale RAM data;
      // any RWAIT re-read already observes the write.
      fwd_mask <= (acc && legal && !HWRITE && wr_done && same_word) ? we : 4'b0000;
    end
  end

  // Address-phase capture and forwarded write data (datapath, no reset).
  always_ff @(posedge HCLK) begin
    if (acc) begin
      addr_q   <= HADDR[ADDR_WIDTH-1:0];
      size_q   <= HSIZE;
      fwd_data <= HWDATA;
    end
  end

  // Merge forwarded lanes over the RAM read word.
  always_comb begin
    HRDATA = ram_q;
    for (int i = 0; i < 4; i++) begin
      if (fwd_mask[i]) HRDATA[8*i +: 8] = fwd_data[8*i +: 8];
    end
  end

  assign HREADYOUT = hreadyout_r;
  assign HRESP     = hresp_r;

endmodule

// File: tb/tb_ahb_ram_ws.sv
// Bench for ahb_ram_ws: three instances (WAIT_STATES 0, 1, 3) exercised in turn
// with a directed vector table, hand-written reset/HREADY sequences and
// randomized back-to-back traffic against a byte-array memory model.
module tb_ahb_ram_ws;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } op_t;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsel      [3];
  logic        hready    [3];
  logic [31:0] haddr     [3];
  logic [1:0]  htrans    [3];
  logic        hwrite    [3];
  logic [2:0]  hsize     [3];
  logic [31:0] hwdata    [3];
  logic [31:0] hrdata    [3];
  logic        hreadyout [3];
  logic        hresp     [3];
  logic        hr_low    [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ahb_ram_ws #(.ADDR_WIDTH(14), .WAIT_STATES(g == 0 ? 0 : (g == 1 ? 1 : 3))) u_dut (
      .HCLK      (clk),
      .HRESET    (rst),
      .HSEL      (hsel[g]),
      .HREADY    (hready[g]),
      .HADDR     (haddr[g]),
      .HTRANS    (htrans[g]),
      .HWRITE    (hwrite[g]),
      .HSIZE     (hsize[g]),
      .HWDATA    (hwdata[g]),
      .HRDATA    (hrdata[g]),
      .HREADYOUT (hreadyout[g]),
      .HRESP     (hresp[g])
    );
    assign hready[g] = hr_low[g] ? 1'b0 : hreadyout[g];
  end

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  mdl [3][256];
  op_t         ops     [16];
  logic [31:0] r_data  [16];
  logic        r_resp  [16];
  logic        r_errf  [16];
  int          r_waits [16];
  vec_t        tbl     [12];

  function automatic int ws_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_addr(input int k, input op_t o);
    hsel[k]   = 1'b1;
    htrans[k] = {1'b1, 1'($urandom_range(0, 1))};
    hwrite[k] = o.wr;
    haddr[k]  = o.addr;
    hsize[k]  = o.size;
  endtask

  task automatic drive_idle(input int k);
    hsel[k]   = 1'b0;
    htrans[k] = 2'b00;
    hwrite[k] = 1'b0;
  endtask

  // Issue ops[0..n-1] back-to-back; record per-op wait count, response and read data.
  task automatic xseq(input int k, input int n);
    int w;
    @(negedge clk);
    drive_addr(k, ops[0]);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      hwdata[k] = ops[i].wdata;
      if (i + 1 < n) drive_addr(k, ops[i+1]);
      else           drive_idle(k);
      w = 0;
      r_errf[i] = 1'b0;
      while (hreadyout[k] === 1'b0 && w < 16) begin
        if (w == 0) r_errf[i] = hresp[k];
        w++;
        @(negedge clk);
      end
      r_waits[i] = w;
      r_resp[i]  = hresp[k];
      r_data[i]  = hrdata[k];
    end
    @(posedge clk);
  endtask

  // Sequential byte-addressed memory: what a read returns and how long it stalls.
  task automatic model_op(input int k, input op_t o, output logic [31:0] erd,
                          output bit eerr, output int ewait);
    int  a, base, n;
    bit  legal;
    a     = int'(o.addr[7:0]);
    base  = a & 252;
    n     = 1 << o.size;
    legal = (o.size == 0) || (o.size == 1 && a % 2 == 0) || (o.size == 2 && a % 4 == 0);
    erd   = {mdl[k][base+3], mdl[k][base+2], mdl[k][base+1], mdl[k][base]};
    eerr  = !legal;
    ewait = !legal ? 1 : (o.wr ? 0 : ws_of(k));
    if (legal && o.wr)
      for (int b = 0; b < n; b++) mdl[k][a+b] = o.wdata[8*((a+b)%4) +: 8];
  endtask

  // Run ops[0..n-1] against the model and compare every observable.
  task automatic run_checked(input int k, input int n, input string tag);
    logic [31:0] erd  [16];
    bit          eerr [16];
    int          ew   [16];
    for (int i = 0; i < n; i++) model_op(k, ops[i], erd[i], eerr[i], ew[i]);
    xseq(k, n);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("ws%0d %s op%0d waits", ws_of(k), tag, i), 32'(r_waits[i]), 32'(ew[i]));
      chk($sformatf("ws%0d %s op%0d resp", ws_of(k), tag, i), 32'(r_resp[i]), 32'(eerr[i]));
      chk($sformatf("ws%0d %s op%0d err1", ws_of(k), tag, i), 32'(r_errf[i]), 32'(eerr[i]));
      if (!ops[i].wr && !eerr[i])
        chk($sformatf("ws%0d %s op%0d rdata", ws_of(k), tag, i), r_data[i], erd[i]);
    end
  endtask

  task automatic rd_op(input int idx, input logic [31:0] a);
    ops[idx] = '{wr: 1'b0, addr: a, size: 3'd2, wdata: 32'h0};
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] dummy_rd;
    bit          dummy_err;
    int          dummy_w;
    int          n;

    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive_idle(k);
      haddr[k] = '0; hsize[k] = '0; hwdata[k] = '0; hr_low[k] = 1'b0;
    end
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("ws%0d reset hreadyout", ws_of(k)), 32'(hreadyout[k]), 32'd1);
      chk($sformatf("ws%0d reset hresp", ws_of(k)), 32'(hresp[k]), 32'd0);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    tbl[0]  = '{1'b1, 32'h10, 3'd2, 32'h12345678, 32'h0,        1'b0};
    tbl[1]  = '{1'b0, 32'h10, 3'd2, 32'h0,        32'h12345678, 1'b0};
    tbl[2]  = '{1'b1, 32'h10, 3'd2, 32'hFFFFFFFF, 32'h0,        1'b0};
    tbl[3]  = '{1'b1, 32'h11, 3'd0, 32'h0000AB00, 32'h0,        1'b0};
    tbl[4]  = '{1'b0, 32'h10, 3'd2, 32'h0,        32'hFFFFABFF, 1'b0};
    tbl[5]  = '{1'b1, 32'h13, 3'd1, 32'h11110000, 32'h0,        1'b1};
    tbl[6]  = '{1'b0, 32'h10, 3'd2, 32'h0,        32'hFFFFABFF, 1'b0};
    tbl[7]  = '{1'b0, 32'h10, 3'd3, 32'h0,        32'h0,        1'b1};
    tbl[8]  = '{1'b0, 32'h10, 3'd2, 32'h0,        32'hFFFFABFF, 1'b0};
    tbl[9]  = '{1'b1, 32'h12, 3'd1, 32'hBEEF0000, 32'h0,        1'b0};
    tbl[10] = '{1'b0, 32'h12, 3'd1, 32'h0,        32'hBEEFABFF, 1'b0};
    tbl[11] = '{1'b1, 32'h20, 3'd2, 32'hCAFEF00D, 32'h0,        1'b0};

    for (int k = 0; k < 3; k++) begin
      // Fill bytes 0x00..0xFF so every later read has a known expectation.
      for (int c = 0; c < 8; c++) begin
        for (int i = 0; i < 8; i++)
          ops[i] = '{wr: 1'b1, addr: 32'((c*8 + i) * 4), size: 3'd2, wdata: $urandom};
        run_checked(k, 8, "init");
      end

      // Directed vectors with hand-derived expectations, issued back-to-back.
      for (int i = 0; i < 12; i++) begin
        ops[i] = '{wr: tbl[i].wr, addr: tbl[i].addr, size: tbl[i].size, wdata: tbl[i].wdata};
        model_op(k, ops[i], dummy_rd, dummy_err, dummy_w);
      end
      xseq(k, 12);
      for (int i = 0; i < 12; i++) begin
        chk($sformatf("ws%0d tbl%0d waits", ws_of(k), i), 32'(r_waits[i]),
            32'(tbl[i].exp_err ? 1 : (tbl[i].wr ? 0 : ws_of(k))));
        chk($sformatf("ws%0d tbl%0d resp", ws_of(k), i), 32'(r_resp[i]), 32'(tbl[i].exp_err));
        chk($sformatf("ws%0d tbl%0d err1", ws_of(k), i), 32'(r_errf[i]), 32'(tbl[i].exp_err));
        if (!tbl[i].wr && !tbl[i].exp_err)
          chk($sformatf("ws%0d tbl%0d rdata", ws_of(k), i), r_data[i], tbl[i].exp_rd);
      end

      // Reset while in ERR1: both outputs return to IDLE values without a clock.
      @(negedge clk);
      drive_addr(k, '{wr: 1'b0, addr: 32'h10, size: 3'd3, wdata: 32'h0});
      @(posedge clk);
      #1 drive_idle(k);
      #1;
      chk($sformatf("ws%0d err1 hresp", ws_of(k)), 32'(hresp[k]), 32'd1);
      chk($sformatf("ws%0d err1 hreadyout", ws_of(k)), 32'(hreadyout[k]), 32'd0);
      rst = 1'b1;
      #1;
      chk($sformatf("ws%0d rst-err hresp", ws_of(k)), 32'(hresp[k]), 32'd0);
      chk($sformatf("ws%0d rst-err hreadyout", ws_of(k)), 32'(hreadyout[k]), 32'd1);
      @(negedge clk);
      rst = 1'b0;

      // Reset while a read is stalled in RWAIT.
      @(negedge clk);
      drive_addr(k, '{wr: 1'b0, addr: 32'h20, size: 3'd2, wdata: 32'h0});
      @(posedge clk);
      #1 drive_idle(k);
      if (ws_of(k) > 0)
        chk($sformatf("ws%0d rwait hreadyout", ws_of(k)), 32'(hreadyout[k]), 32'd0);
      #1 rst = 1'b1;
      #1;
      chk($sformatf("ws%0d rst-rwait hreadyout", ws_of(k)), 32'(hreadyout[k]), 32'd1);
      chk($sformatf("ws%0d rst-rwait hresp", ws_of(k)), 32'(hresp[k]), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      rd_op(0, 32'h20);
      xseq(k, 1);
      chk($sformatf("ws%0d after-rst @20", ws_of(k)), r_data[0], 32'hCAFEF00D);
      chk($sformatf("ws%0d after-rst waits", ws_of(k)), 32'(r_waits[0]), 32'(ws_of(k)));

      // Write whose data phase is cut by reset must leave memory untouched.
      @(negedge clk);
      drive_addr(k, '{wr: 1'b1, addr: 32'h30, size: 3'd2, wdata: 32'h0});
      @(posedge clk);
      #1 drive_idle(k);
      hwdata[k] = 32'h0BADF00D;
      #1 rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      rd_op(0, 32'h30);
      run_checked(k, 1, "rst-write");

      // HREADY held low with a write on the bus: nothing may be accepted.
      @(negedge clk);
      hr_low[k] = 1'b1;
      drive_addr(k, '{wr: 1'b1, addr: 32'h40, size: 3'd2, wdata: 32'h0});
      hwdata[k] = 32'hDEADBEEF;
      for (int c = 0; c < 3; c++) begin
        @(posedge clk);
        #1;
        chk($sformatf("ws%0d hready-low c%0d hreadyout", ws_of(k), c), 32'(hreadyout[k]), 32'd1);
        chk($sformatf("ws%0d hready-low c%0d hresp", ws_of(k), c), 32'(hresp[k]), 32'd0);
      end
      @(negedge clk);
      drive_idle(k);
      hr_low[k] = 1'b0;
      rd_op(0, 32'h40);
      rd_op(1, 32'h44);
      run_checked(k, 2, "hready-low");

      // Randomized back-to-back traffic, biased towards a small hot region.
      for (int s = 0; s < 30; s++) begin
        n = 1 + int'($urandom_range(0, 3));
        for (int i = 0; i < n; i++) begin
          ops[i].wr    = 1'($urandom_range(0, 1));
          ops[i].size  = 3'($urandom_range(0, 3));
          ops[i].addr  = $urandom_range(0, 1) ? 32'(32'h50 + $urandom_range(0, 15))
                                              : 32'($urandom_range(0, 255));
          ops[i].wdata = $urandom;
        end
        run_checked(k, n, $sformatf("rnd%0d", s));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_ram_ws.md
AHB_RAM_WS -- requirements
Module: ahb_ram_ws

Interface
REQ-001 Parameters SHALL be:
- ADDR_WIDTH, 14, byte-address bits decoded (10..16); depth = 2^(ADDR_WIDTH-2) words.
- WAIT_STATES, 0, read wait states inserted (0..3).
REQ-002 Ports SHALL be:
- HCLK  in  1  bus clock; the only clock.
- HRESET  in  1  asynchronous, active-high reset.
- HSEL  in  1  slave select.
- HREADY  in  1  bus ready (previous transfer completing).
- HADDR  in  32  address.
- HTRANS  in  2  transfer type; only bit 1 is decoded.
- HWRITE  in  1  write transfer.
- HSIZE  in  3  transfer size.
- HWDATA  in  32  write data.
- HRDATA  out  32  read data.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.

Function
REQ-003 A transfer SHALL be accepted on a rising HCLK edge only when HSEL & HTRANS[1] & HREADY; address-phase signals are registered at acceptance.
REQ-004 A transfer SHALL be legal iff HSIZE is 0, HSIZE is 1 with HADDR[0]=0, or HSIZE is 2 with HADDR[1:0]=0.
REQ-005 FSM states SHALL be IDLE, RWAIT, ERR1, ERR2:
- IDLE: accept a legal read with WAIT_STATES>0 -> RWAIT; accept an illegal transfer -> ERR1; otherwise stay.
- RWAIT -> IDLE when the wait counter reaches WAIT_STATES.
- ERR1 -> ERR2 unconditionally.
- ERR2 -> IDLE, or ERR1/RWAIT if a new transfer is accepted in the same cycle.
REQ-006 Outputs per state SHALL be:
- IDLE: HREADYOUT=1, HRESP=0.
- RWAIT: HREADYOUT=0, HRESP=0.
- ERR1: HREADYOUT=0, HRESP=1.
- ERR2: HREADYOUT=1, HRESP=1.
REQ-007 A legal write SHALL complete in zero wait states; byte lanes are written at the end of its data-phase cycle using the registered address and size and the current HWDATA.
REQ-008 Byte enables SHALL be one-hot for bytes (lane = HADDR[1:0]), lanes 1:0 or 3:2 for halfwords, and all four lanes for words.
REQ-009 An illegal transfer SHALL never modify memory.
REQ-010 Read latency SHALL be WAIT_STATES+1 cycles from acceptance to valid HRDATA.
REQ-011 The read port address SHALL be HADDR at acceptance and the registered address during RWAIT, so the final RWAIT cycle re-reads the word.
REQ-012 A read accepted in the data phase of a write to the same word SHALL return the newly written bytes on written lanes and RAM data on the other lanes, for any WAIT_STATES.
REQ-013 The wait counter SHALL be 2 bits, cleared on entry to RWAIT; with WAIT_STATES=0, RWAIT is unreachable.
REQ-014 HRDATA SHALL be the full word regardless of HSIZE; it is don't-care outside the read data phase.
REQ-015 While HREADY=0 and the FSM is in IDLE, registered address-phase state SHALL hold.
REQ-016 Back-to-back transfers SHALL be supported with no idle cycle in between.

Reset
REQ-017 Asserting HRESET SHALL immediately force IDLE, HREADYOUT=1, HRESP=0, clear the registered active/write flags and forwarding mask, and zero the wait counter.
REQ-018 Reset SHALL not clear memory contents; a write whose data phase is interrupted by reset is discarded.

Structure
REQ-019 Package ahb_ram_pkg SHALL hold the HTRANS and HSIZE encodings, the HRESP codes, and the FSM state type.
REQ-020 Sub-module ahb_ram_bytemem SHALL implement a simple dual-port RAM with 4 byte-write lanes, a synchronous read port, a read-during-write result of old data, and depth parameterised from ADDR_WIDTH.

Verification
REQ-021 Benches SHALL run with WAIT_STATES = 0, 1 and 3, and SHALL cover:
- Word write 0x12345678 @0x10, then read @0x10 -> 0x12345678 on HRDATA after WAIT_STATES+1 cycles, with HREADYOUT low for exactly WAIT_STATES cycles.
- Byte write 0xAB @0x11 over 0xFFFFFFFF, read back-to-back @0x10 -> 0xFFFFABFF (forwarding), also with WAIT_STATES=0.
- Halfword write @0x13 -> ERR1 then ERR2 HRESP pattern, and a later read @0x10 is unchanged.
- HSIZE=3 read -> two-cycle ERROR response; the next legal read -> OKAY.
- HRESET pulsed in RWAIT -> HREADYOUT=1 and HRESP=0 asynchronously; a prior write @0x20 of 0xCAFEF00D still reads back intact.
- HREADY=0 held for 3 cycles with HSEL=1 -> no transfer accepted and memory unchanged.
